// File: rtl/dmaw_packer.sv
// dmaw_packer: packs a narrow user write stream into AXI_DW-wide beats with
// byte strobes and a last flag for the DMA write partitioner.
// Optional build macro DMAW_PACKER_BSWAP_EN byte-reverses each input word
// before lane placement (big-endian source). Strobes are unaffected.
//
// Stream handshakes (cfg, in, dmaw): a transfer happens on a rising edge where
// valid and ready are both 1. A producer keeps valid and its payload stable
// until that edge, and ready may depend combinationally on the other side.
module dmaw_packer #(
    parameter int AXI_DW = 128,
    parameter int IN_DW  = 32
) (
    input  logic                  usr_clk,
    input  logic                  usr_reset_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [31:0]           cfg_len,
    input  logic [IN_DW-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [AXI_DW-1:0]     dmaw_data,
    output logic [AXI_DW/8-1:0]   dmaw_strb,
    output logic                  dmaw_last,
    output logic                  dmaw_valid,
    input  logic                  dmaw_ready,
    output logic [1:0]            dbg_state
);

    localparam int AXI_BYTES  = AXI_DW / 8;
    localparam int AXI_WSTRBW = AXI_BYTES;
    localparam int IN_BYTES   = IN_DW / 8;
    localparam int RATIO      = AXI_DW / IN_DW;
    localparam int IDXW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDXW-1:0] IDX_MAX  = IDXW'(RATIO - 1);
    localparam logic [31:0]     IN_BYTES_L = 32'(IN_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [31:0]             r_rem;
    logic [IDXW-1:0]         r_idx;
    logic [AXI_DW-1:0]       r_acc_data;
    logic [AXI_WSTRBW-1:0]   r_acc_strb;
    logic [AXI_DW-1:0]       r_out_data;
    logic [AXI_WSTRBW-1:0]   r_out_strb;
    logic                    r_out_last;
    logic                    r_out_valid;

    logic                    w_in_hs;
    logic                    w_cfg_start;
    logic                    w_final;
    logic                    w_launch;
    logic [31:0]             w_take;
    logic [IN_DW-1:0]        w_word;
    logic [IN_BYTES-1:0]     w_slot_strb;
    logic [AXI_DW-1:0]       w_beat_data;
    logic [AXI_WSTRBW-1:0]   w_beat_strb;

    assign dmaw_data  = r_out_data;
    assign dmaw_strb  = r_out_strb;
    assign dmaw_last  = r_out_last;
    assign dmaw_valid = r_out_valid;
    assign dbg_state  = r_state;

    assign w_cfg_start = (r_state == ST_IDLE) && cfg_valid && (cfg_len != 32'd0);
    assign w_in_hs     = in_valid && in_ready;
    // Saturating min keeps rem from wrapping on the short last word.
    assign w_take      = (r_rem < IN_BYTES_L) ? r_rem : IN_BYTES_L;
    assign w_final     = (r_rem <= IN_BYTES_L);
    assign w_launch    = w_in_hs && ((r_idx == IDX_MAX) || w_final);

    // Optional byte reversal of the incoming word.
    always_comb begin
        w_word = in_data;
`ifdef DMAW_PACKER_BSWAP_EN
        for (int b = 0; b < IN_BYTES; b++) begin
            w_word[b*8 +: 8] = in_data[(IN_BYTES-1-b)*8 +: 8];
        end
`else
        w_word = in_data;
`endif
    end

    // Merge the current word and its strobes into the accumulating beat.
    always_comb begin
        w_slot_strb = '0;
        for (int b = 0; b < IN_BYTES; b++) begin
            w_slot_strb[b] = (32'(b) < w_take);
        end
        w_beat_data = r_acc_data;
        w_beat_strb = r_acc_strb;
        w_beat_data[int'(r_idx)*IN_DW +: IN_DW]       = w_word;
        w_beat_strb[int'(r_idx)*IN_BYTES +: IN_BYTES] = w_slot_strb;
    end

    // FSM state register.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake readies.
    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        in_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (w_cfg_start) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // One output register: accept a word only if the register
                // is empty or being emptied this cycle.
                in_ready = !r_out_valid || dmaw_ready;
                if (w_launch && w_final) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_out_valid && dmaw_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Byte counter, lane index and accumulator.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            r_rem      <= '0;
            r_idx      <= '0;
            r_acc_data <= '0;
            r_acc_strb <= '0;
        end else if (w_cfg_start) begin
            r_rem      <= cfg_len;
            r_idx      <= '0;
            r_acc_data <= '0;
            r_acc_strb <= '0;
        end else if (w_in_hs) begin
            r_rem <= r_rem - w_take;
            if (w_launch) begin
                r_idx      <= '0;
                r_acc_data <= '0;
                r_acc_strb <= '0;
            end else begin
                r_idx      <= r_idx + 1'b1;
                r_acc_data <= w_beat_data;
                r_acc_strb <= w_beat_strb;
            end
        end
    end

    // Output beat register; a load may coincide with the previous handshake.
    always_ff @(posedge usr_clk) begin
        if (!usr_reset_n) begin
            r_out_data  <= '0;
            r_out_strb  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_launch) begin
            r_out_data  <= w_beat_data;
            r_out_strb  <= w_beat_strb;
            r_out_last  <= w_final;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && dmaw_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmaw_packer.sv
// Directed bench for dmaw_packer with default parameters (128/32).
module tb_dmaw_packer;

  logic         clk;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [31:0]  cfg_len;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dmaw_data;
  logic [15:0]  dmaw_strb;
  logic         dmaw_last;
  logic         dmaw_valid;
  logic         dmaw_ready;
  logic [1:0]   dbg_state;

  int n_total;
  int n_bad;
  int in_cnt;

  logic [127:0] exp_q[$];
  logic [15:0]  exp_strb_q[$];
  logic         exp_last_q[$];

  dmaw_packer dut (
    .usr_clk     (clk),
    .usr_reset_n (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_len     (cfg_len),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dmaw_data   (dmaw_data),
    .dmaw_strb   (dmaw_strb),
    .dmaw_last   (dmaw_last),
    .dmaw_valid  (dmaw_valid),
    .dmaw_ready  (dmaw_ready),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: compare every accepted beat against the expected queue
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) in_cnt++;
    if (rst_n && dmaw_valid && dmaw_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        chk("beat_data", dmaw_data, exp_q.pop_front());
        chk("beat_strb", {112'd0, dmaw_strb}, {112'd0, exp_strb_q.pop_front()});
        chk("beat_last", {127'd0, dmaw_last}, {127'd0, exp_last_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic exp_beat(input logic [127:0] d, input logic [15:0] s, input logic l);
    exp_q.push_back(d);
    exp_strb_q.push_back(s);
    exp_last_q.push_back(l);
  endtask

  task automatic start_cfg(input logic [31:0] len);
    int t;
    cfg_valid = 1'b1;
    cfg_len   = len;
    t = 0;
    @(negedge clk);
    while (!cfg_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cfg_ready) chk("cfg_timeout", 0, 1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // waits for the last-beat handshake, then checks cfg_ready timing
  task automatic wait_last(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!(dmaw_valid && dmaw_ready && dmaw_last) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_last_seen"}, {127'd0, dmaw_valid && dmaw_last}, 1);
    chk({tag, "_cfg_busy"}, {127'd0, cfg_ready}, 0);
    @(negedge clk);
    chk({tag, "_cfg_idle"}, {127'd0, cfg_ready}, 1);
    chk({tag, "_valid_low"}, {127'd0, dmaw_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    in_cnt     = 0;
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_len    = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    dmaw_ready = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;

    // reset state
    @(negedge clk);
    chk("rst_cfg_ready", {127'd0, cfg_ready}, 1);
    chk("rst_in_ready", {127'd0, in_ready}, 0);
    chk("rst_valid", {127'd0, dmaw_valid}, 0);
    chk("rst_last", {127'd0, dmaw_last}, 0);
    chk("rst_data", dmaw_data, 0);
    chk("rst_strb", {112'd0, dmaw_strb}, 0);
    chk("rst_state", {126'd0, dbg_state}, 0);
    @(posedge clk);
    #1;

`ifdef DMAW_PACKER_BSWAP_EN
    // byte-swapped single word
    exp_beat(128'h44332211, 16'h000F, 1'b1);
    start_cfg(32'd4);
    send_word(32'h11223344);
    wait_last("bswap");
`else
    // two full beats
    in_cnt = 0;
    exp_beat(128'h00000003_00000002_00000001_00000000, 16'hFFFF, 1'b0);
    exp_beat(128'h00000007_00000006_00000005_00000004, 16'hFFFF, 1'b1);
    start_cfg(32'd32);
    for (int i = 0; i < 8; i++) send_word(32'(i));
    wait_last("len32");
    chk("len32_words", 128'(in_cnt), 8);

    // short final beat, sixth word refused
    in_cnt = 0;
    exp_beat(128'h00000013_00000012_00000011_00000010, 16'hFFFF, 1'b0);
    exp_beat(128'h00000000_00000000_00000000_00000014, 16'h000F, 1'b1);
    start_cfg(32'd20);
    for (int i = 0; i < 5; i++) send_word(32'h10 + 32'(i));
    in_data  = 32'h15;
    in_valid = 1'b1;
    wait_last("len20");
    idle_cycles(3);
    @(negedge clk);
    chk("len20_in_ready", {127'd0, in_ready}, 0);
    chk("len20_words", 128'(in_cnt), 5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    // six bytes in one beat
    exp_beat(128'h00000000_00000000_B1B2B3B4_A1A2A3A4, 16'h003F, 1'b1);
    start_cfg(32'd6);
    send_word(32'hA1A2A3A4);
    send_word(32'hB1B2B3B4);
    wait_last("len6");

    // output stall
    in_cnt = 0;
    dmaw_ready = 1'b0;
    exp_beat(128'h00000023_00000022_00000021_00000020, 16'hFFFF, 1'b0);
    exp_beat(128'h00000027_00000026_00000025_00000024, 16'hFFFF, 1'b1);
    start_cfg(32'd32);
    fork
      begin
        for (int i = 0; i < 8; i++) send_word(32'h20 + 32'(i));
      end
      begin
        int t;
        t = 0;
        @(negedge clk);
        while (!dmaw_valid && t < 100) begin
          @(negedge clk);
          t++;
        end
        chk("stall_valid", {127'd0, dmaw_valid}, 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("stall_data", dmaw_data, 128'h00000023_00000022_00000021_00000020);
          chk("stall_strb", {112'd0, dmaw_strb}, 128'hFFFF);
          chk("stall_in_ready", {127'd0, in_ready}, 0);
        end
        chk("stall_words", 128'(in_cnt), 4);
        @(posedge clk);
        #1;
        dmaw_ready = 1'b1;
      end
    join
    wait_last("stall");
    chk("stall_total_words", 128'(in_cnt), 8);

    // zero-length request
    start_cfg(32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("len0_cfg_ready", {127'd0, cfg_ready}, 1);
      chk("len0_valid", {127'd0, dmaw_valid}, 0);
    end
    @(posedge clk);
    #1;

    // reset in the middle of a transfer
    start_cfg(32'd64);
    for (int i = 0; i < 3; i++) send_word(32'hE0 + 32'(i));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_valid", {127'd0, dmaw_valid}, 0);
    chk("mrst_cfg_ready", {127'd0, cfg_ready}, 1);
    chk("mrst_in_ready", {127'd0, in_ready}, 0);
    chk("mrst_state", {126'd0, dbg_state}, 0);
    @(posedge clk);
    #1;

    // fresh transfer after reset sees no stale lanes
    exp_beat(128'h00000000_00000000_00000000_00000055, 16'h000F, 1'b1);
    start_cfg(32'd4);
    send_word(32'h55);
    wait_last("post_rst");
`endif

    idle_cycles(3);
    chk("beats_left", 128'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
